// File: rtl/gain_ramp_ctrl.sv
// Gain ramp controller: slews a signed 30-bit scale toward a target
// one step per stream sample, with mute and immediate-jump support.
module gain_ramp_ctrl #(
    parameter logic signed [29:0] RESET_SCALE = 30'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        load,
    input  logic [31:0] target_in,
    input  logic [29:0] step_in,
    input  logic        mute,
    output logic [31:0] scale,
    output logic        busy,
    output logic        done,
    output logic        at_target
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EVAL      = 2'd1,
        RAMP_UP   = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t             r_state;
    logic signed [29:0] r_scale;
    logic signed [29:0] r_tgt;
    logic        [29:0] r_stp;
    logic               r_done;
    logic               r_mute_q;

    state_t             w_state_nxt;
    logic signed [29:0] w_scale_nxt;
    logic               w_done_nxt;
    logic signed [29:0] w_eff;
    logic signed [29:0] w_tgt_sat;
    logic signed [31:0] w_eff_x;
    logic signed [31:0] w_scl_x;
    logic signed [31:0] w_stp_x;
    logic signed [31:0] w_up;
    logic signed [31:0] w_dn;
    logic               w_mute_edge;

    // Top three bits agreeing means the value already fits in 30 bits.
    always_comb begin
        w_tgt_sat = target_in[29:0];
        if (target_in[31:29] != 3'b000 && target_in[31:29] != 3'b111) begin
            w_tgt_sat = target_in[31] ? 30'sh2000_0000 : 30'sh1FFF_FFFF;
        end
    end

    assign w_mute_edge = mute ^ r_mute_q;
    assign w_eff       = mute ? 30'sd0 : r_tgt;
    assign w_eff_x     = {{2{w_eff[29]}}, w_eff};
    assign w_scl_x     = {{2{r_scale[29]}}, r_scale};
    assign w_stp_x     = {2'b00, r_stp};
    assign w_up        = w_eff_x - w_scl_x;
    assign w_dn        = w_scl_x - w_eff_x;

    always_comb begin
        w_state_nxt = r_state;
        w_scale_nxt = r_scale;
        w_done_nxt  = 1'b0;
        if (load || w_mute_edge) begin
            w_state_nxt = EVAL;
        end else begin
            unique case (r_state)
                IDLE: ;
                EVAL: begin
                    if (r_scale == w_eff) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_stp == 30'd0) begin
                        w_scale_nxt = w_eff;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_eff > r_scale) begin
                        w_state_nxt = RAMP_UP;
                    end else begin
                        w_state_nxt = RAMP_DOWN;
                    end
                end
                RAMP_UP: begin
                    if (sample_en) begin
                        if (w_up <= w_stp_x) begin
                            w_scale_nxt = w_eff;
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_scale_nxt = r_scale + r_stp;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (sample_en) begin
                        if (w_dn <= w_stp_x) begin
                            w_scale_nxt = w_eff;
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_scale_nxt = r_scale - r_stp;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_scale  <= RESET_SCALE;
            r_tgt    <= RESET_SCALE;
            r_stp    <= 30'd0;
            r_done   <= 1'b0;
            r_mute_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_scale  <= w_scale_nxt;
            r_done   <= w_done_nxt;
            r_mute_q <= mute;
            if (load) begin
                r_tgt <= w_tgt_sat;
                r_stp <= step_in;
            end
        end
    end

    assign scale     = {{2{r_scale[29]}}, r_scale};
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign at_target = (r_state == IDLE) && (r_scale == w_eff);

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed bench for gain_ramp_ctrl; expected values computed by hand
// from the ramp rules (load/mute -> EVAL -> ramp per sample_en).
module tb_gain_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic        load;
    logic [31:0] target_in;
    logic [29:0] step_in;
    logic        mute;
    logic [31:0] scale;
    logic        busy;
    logic        done;
    logic        at_target;

    int n_chk;
    int n_fail;

    gain_ramp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .load      (load),
        .target_in (target_in),
        .step_in   (step_in),
        .mute      (mute),
        .scale     (scale),
        .busy      (busy),
        .done      (done),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] t, input logic [29:0] s);
        load      = 1'b1;
        target_in = t;
        step_in   = s;
        tick();
        load = 1'b0;
    endtask

    logic [31:0] up_seq [4];
    logic [31:0] dn_seq [3];

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sample_en = 1'b0;
        load      = 1'b0;
        target_in = '0;
        step_in   = '0;
        mute      = 1'b0;
        up_seq    = '{32'h4000, 32'h8000, 32'hC000, 32'h10000};
        dn_seq    = '{32'hB000, 32'h6000, 32'h1000};

        tick();
        chk("rst_scale", scale, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_at", {31'd0, at_target}, 32'd1);
        rst = 1'b0;
        tick();

        // Ramp up with load and sample_en coinciding: load wins.
        sample_en = 1'b1;
        do_load(32'h0001_0000, 30'h4000);
        chk("up_eval_busy", {31'd0, busy}, 32'd1);
        chk("up_eval_scale", scale, 32'h0);
        tick();
        chk("up_eval_hold", scale, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("up_step", scale, up_seq[i]);
            chk("up_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("up_busy_end", {31'd0, busy}, 32'd0);
        chk("up_at", {31'd0, at_target}, 32'd1);
        tick();
        chk("up_done_clr", {31'd0, done}, 32'd0);

        // Ramp down, must stop exactly at the target.
        do_load(32'h0000_1000, 30'h5000);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dn_step", scale, dn_seq[i]);
            chk("dn_done", {31'd0, done}, (i == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("dn_hold", scale, 32'h1000);

        // Immediate jump with positive saturation.
        do_load(32'h7FFF_FFFF, 30'd0);
        chk("sat_eval", scale, 32'h1000);
        tick();
        chk("sat_pos", scale, 32'h1FFF_FFFF);
        chk("sat_done", {31'd0, done}, 32'd1);
        tick();
        chk("sat_done_clr", {31'd0, done}, 32'd0);

        do_load(32'h8000_0000, 30'd0);
        tick();
        chk("sat_neg", scale, 32'hE000_0000);
        do_load(32'h0, 30'd0);
        tick();
        chk("jump_zero", scale, 32'h0);
        tick();

        // Mute mid-ramp, then unmute.
        do_load(32'h0001_0000, 30'h4000);
        tick();
        tick();
        tick();
        chk("mu_pre", scale, 32'h8000);
        mute = 1'b1;
        tick();
        chk("mu_eval_scale", scale, 32'h8000);
        chk("mu_eval_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("mu_dn1", scale, 32'h4000);
        tick();
        chk("mu_dn2", scale, 32'h0);
        chk("mu_done", {31'd0, done}, 32'd1);
        tick();
        chk("mu_at", {31'd0, at_target}, 32'd1);
        mute = 1'b0;
        tick();
        chk("um_eval", {31'd0, busy}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("um_step", scale, up_seq[i]);
            chk("um_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
        end
        tick();

        // No sample_en: scale holds, busy stays high.
        do_load(32'h0002_0000, 30'h1000);
        sample_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_scale", scale, 32'h10000);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        sample_en = 1'b1;
        tick();
        chk("hold_step", scale, 32'h11000);

        // Reset mid-ramp overrides a simultaneous load.
        rst       = 1'b1;
        load      = 1'b1;
        target_in = 32'h0003_0000;
        tick();
        chk("mr_scale", scale, 32'h0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_at", {31'd0, at_target}, 32'd1);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        chk("mr_after", {31'd0, busy}, 32'd0);

        // Mute held through reset is seen as an edge afterwards.
        rst  = 1'b1;
        mute = 1'b1;
        tick();
        chk("rm_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rm_eval", {31'd0, busy}, 32'd1);
        tick();
        chk("rm_done", {31'd0, done}, 32'd1);
        chk("rm_at", {31'd0, at_target}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gain_ramp_ctrl.md
GAIN_RAMP_CTRL -- requirements
Module: gain_ramp_ctrl

Interface
REQ-001 Parameter: RESET_SCALE, 30'sd0, signed 30-bit scale value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: sample_en  input  1  one-cycle strobe per stream sample; ramp advances only on this strobe.
REQ-005 Port: load  input  1  one-cycle pulse; captures target_in and step_in.
REQ-006 Port: target_in  input  32  requested scale, signed; 32'h0001_0000 = unity for the downstream gain multiplier.
REQ-007 Port: step_in  input  30  unsigned ramp increment per sample; 0 = immediate jump.
REQ-008 Port: mute  input  1  level; while high, effective target is 0.
REQ-009 Port: scale  output  32  current scale to the multiplier; 30-bit signed value sign-extended to 32 bits.
REQ-010 Port: busy  output  1  high in states EVAL, RAMP_UP and RAMP_DOWN.
REQ-011 Port: done  output  1  one-cycle pulse when scale reaches the effective target.
REQ-012 Port: at_target  output  1  high when scale equals the effective target and state is IDLE.

Function
REQ-013 States SHALL be IDLE, EVAL, RAMP_UP and RAMP_DOWN, all registered.
REQ-014 On load, target_in SHALL be saturated to the signed 30-bit range [-2^29, 2^29-1] and stored as tgt.
REQ-015 On load, step_in SHALL be stored as stp, and the state SHALL go to EVAL at the same edge, from any state.
REQ-016 A mute edge (rise or fall, detected against a registered copy) SHALL force EVAL at the next edge, from any state.
REQ-017 Effective target eff SHALL be 0 when mute=1, otherwise tgt.
REQ-018 EVAL SHALL last exactly one cycle and then resolve as follows:
  - scale==eff -> IDLE, pulse done;
  - stp==0 -> scale=eff, IDLE, pulse done;
  - eff>scale -> RAMP_UP;
  - eff<scale -> RAMP_DOWN.
REQ-019 In RAMP_UP, on sample_en: if (eff-scale)<=stp then scale=eff, IDLE, pulse done; else scale=scale+stp.
REQ-020 In RAMP_DOWN, on sample_en: if (scale-eff)<=stp then scale=eff, IDLE, pulse done; else scale=scale-stp.
REQ-021 Differences and sums SHALL be computed at 31 bits signed or wider; scale SHALL never overshoot eff or wrap.
REQ-022 Without sample_en, scale SHALL hold in every state.
REQ-023 If load and sample_en coincide, load SHALL win and no step is taken that cycle.
REQ-024 If load and a mute edge coincide, tgt and stp SHALL update, state SHALL go to EVAL, and eff SHALL follow the new mute level.
REQ-025 A load during a ramp SHALL keep the current scale as the starting point; it SHALL NOT jump to the old target.
REQ-026 scale SHALL change at most once per cycle and only on an edge where the state is EVAL, RAMP_UP or RAMP_DOWN.
REQ-027 Latency: load at edge N -> EVAL during cycle N+1 -> first possible scale change at edge N+1 (stp==0) or at the first sample_en edge after N+1.
REQ-028 done SHALL be a registered pulse, high for exactly one cycle per completion.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, scale=sign-extended RESET_SCALE, tgt=RESET_SCALE, stp=0, done=0, busy=0.
REQ-030 After reset, at_target SHALL be 1 when mute=0; with mute=1 and RESET_SCALE!=0, at_target SHALL be 0 and the mute-edge register SHALL reset to 0, so EVAL starts next cycle.
REQ-031 rst SHALL override load, mute and sample_en in the same cycle; a reset mid-ramp SHALL abort the ramp with no done pulse.

Verification
REQ-032 Reset, then load target 0x0001_0000 with step 0x4000 and sample_en every cycle -> scale 0x4000, 0x8000, 0xC000, 0x10000; done on the 4th step; busy low after.
REQ-033 From 0x10000, load target 0x0000_1000 with step 0x5000 -> scale 0xB000, 0x6000, 0x1000; no value below 0x1000.
REQ-034 Load target 0x7FFF_FFFF with step 0 -> scale=0x1FFF_FFFF at edge N+1; done pulses once.
REQ-035 Mid-ramp, assert mute -> ramp down to 0 at the stored stp; deassert mute -> ramp back to tgt; done pulses at each end.
REQ-036 Load and sample_en on the same cycle, then sample_en held low for 10 cycles -> scale unchanged and busy high throughout.
REQ-037 Assert rst mid-ramp with RESET_SCALE=0 -> next cycle scale=0, busy=0, done=0, at_target=1 (mute=0).
